// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops, radix-2 Booth multiply
// and restoring signed divide, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; only state with busy=0
// MUL   | one Booth step per cycle, WIDTH steps
// DIV   | one restoring-division step per cycle on magnitudes, WIDTH steps
// FIX   | apply quotient/remainder signs
// FIN   | write results, pulse done, return to IDLE
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             carry,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_VAL    = WIDTH[WIDTH-1:0];

  localparam logic [3:0] OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_MUL = 4'b0011,
                         OP_DIV = 4'b0101, OP_AND = 4'b0110, OP_OR  = 4'b0111,
                         OP_NEG = 4'b1000, OP_NOT = 4'b1010, OP_SHL = 4'b1100,
                         OP_SHR = 4'b1101, OP_ROL = 4'b1110, OP_ROR = 4'b1111;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, FIN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q_reg;
  logic             q_m1;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) begin
        if (op == OP_MUL)                      state_d = MUL;
        else if (op == OP_DIV && b != '0)      state_d = DIV;
        else                                   state_d = FIN;
      end
      MUL:  if (cnt == '0) state_d = FIN;
      DIV:  if (cnt == '0) state_d = FIX;
      FIX:  state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Booth step: multiplicand a_r, multiplier shifts through q_reg
  logic [WIDTH:0] m_ext, booth_sum;
  assign m_ext = {a_r[WIDTH-1], a_r};
  always_comb begin
    case ({q_reg[0], q_m1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
  end

  // Restoring step; |b| <= 2^(WIDTH-1) keeps r_shift below 2^WIDTH
  logic [WIDTH-1:0] a_mag_in, b_mag;
  logic [WIDTH:0]   r_shift, r_diff;
  assign a_mag_in = a[WIDTH-1]   ? -a   : a;
  assign b_mag    = b_r[WIDTH-1] ? -b_r : b_r;
  assign r_shift  = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
  assign r_diff   = r_shift - {1'b0, b_mag};

  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] rot_amt, shl_res, shr_res, rol_res, ror_res;
  assign add_full = {1'b0, a_r} + {1'b0, b_r};
  assign sub_full = {1'b0, a_r} - {1'b0, b_r};
  assign rot_amt  = b_r % W_VAL;
  assign shl_res  = (b_r >= W_VAL) ? '0 : (a_r << b_r);
  assign shr_res  = (b_r >= W_VAL) ? '0 : (a_r >> b_r);
  assign rol_res  = (a_r << rot_amt) | (a_r >> (W_VAL - rot_amt));
  assign ror_res  = (a_r >> rot_amt) | (a_r << (W_VAL - rot_amt));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_r <= '0; a_r <= '0; b_r <= '0;
      acc <= '0; q_reg <= '0; q_m1 <= 1'b0; cnt <= '0;
      done <= 1'b0; lo <= '0; hi <= '0; carry <= 1'b0; div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          op_r <= op; a_r <= a; b_r <= b;
          acc  <= '0; q_m1 <= 1'b0; cnt <= CNT_LOAD;
          q_reg <= (op == OP_DIV) ? a_mag_in : b;
        end
        MUL: begin
          acc   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          q_reg <= {booth_sum[0], q_reg[WIDTH-1:1]};
          q_m1  <= q_reg[0];
          cnt   <= cnt - 1'b1;
        end
        DIV: begin
          acc   <= r_diff[WIDTH] ? r_shift : r_diff;
          q_reg <= {q_reg[WIDTH-2:0], ~r_diff[WIDTH]};
          cnt   <= cnt - 1'b1;
        end
        FIX: begin
          if (a_r[WIDTH-1] ^ b_r[WIDTH-1]) q_reg <= -q_reg;
          if (a_r[WIDTH-1]) acc <= {1'b0, -acc[WIDTH-1:0]};
        end
        FIN: begin
          done     <= 1'b1;
          carry    <= 1'b0;
          div_zero <= 1'b0;
          case (op_r)
            OP_ADD: begin lo <= add_full[WIDTH-1:0]; carry <= add_full[WIDTH]; end
            OP_SUB: begin lo <= sub_full[WIDTH-1:0]; carry <= ~sub_full[WIDTH]; end
            OP_MUL: begin lo <= q_reg; hi <= acc[WIDTH-1:0]; end
            OP_DIV: begin
              if (b_r == '0) begin
                lo <= '1; hi <= a_r; div_zero <= 1'b1;
              end else begin
                lo <= q_reg; hi <= acc[WIDTH-1:0];
              end
            end
            OP_AND: lo <= a_r & b_r;
            OP_OR:  lo <= a_r | b_r;
            OP_NEG: lo <= ~b_r + 1'b1;
            OP_NOT: lo <= ~b_r;
            OP_SHL: lo <= shl_res;
            OP_SHR: lo <= shr_res;
            OP_ROL: lo <= rol_res;
            OP_ROR: lo <= ror_res;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: hand-computed results, latencies and protocol cases.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, carry, div_zero;
  logic [W-1:0] lo, hi;

  int checks = 0;
  int errors = 0;
  int lat, busy_cnt, done_cnt;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .lo(lo), .hi(hi), .carry(carry), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, optionally pulse an ignored add at cycle inj, wait for done.
  task automatic run(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input int inj);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cnt++;
      if (lat == inj) begin start = 1'b1; op = 4'b0001; a = 32'h1; b = 32'h1; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("done_seen", {63'd0, done}, 64'd1);
  endtask

  initial begin
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_lo_hi", {hi, lo}, 64'd0);
    chk("rst_flags", {62'd0, carry, div_zero}, 64'd0);
    clr = 1'b1;
    repeat (2) @(posedge clk);

    run(4'b0001, 32'hFFFF_FFFF, 32'h1, -1);
    chk("add_lat", lat, 1);
    chk("add_lo", lo, 0);
    chk("add_carry", carry, 1);
    chk("add_hi", hi, 0);

    run(4'b0011, -32'sd7, 32'd6, -1);
    chk("mul_lat", lat, 33);
    chk("mul_busy_cycles", busy_cnt, 33);
    chk("mul_busy_at_done", busy, 0);
    chk("mul_prod", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);
    chk("mul_carry", carry, 0);

    run(4'b0011, 32'h8000_0000, 32'h8000_0000, -1);
    chk("mul_minmin", {hi, lo}, 64'h4000_0000_0000_0000);

    run(4'b0101, -32'sd17, 32'd5, -1);
    chk("div_lat", lat, 34);
    chk("div_q_r", {hi, lo}, 64'hFFFF_FFFE_FFFF_FFFD);
    chk("div_dz", div_zero, 0);

    run(4'b0101, 32'd17, -32'sd5, -1);
    chk("div_pos_neg", {hi, lo}, 64'h0000_0002_FFFF_FFFD);

    run(4'b0101, 32'd10, 32'd0, -1);
    chk("div0_lat", lat, 1);
    chk("div0_res", {hi, lo}, 64'h0000_000A_FFFF_FFFF);
    chk("div0_dz", div_zero, 1);
    repeat (3) @(posedge clk); #1;
    chk("dz_hold", div_zero, 1);
    chk("done_one_cycle", done, 0);

    run(4'b0010, 32'd5, 32'd7, -1);
    chk("sub_lo", lo, 32'hFFFF_FFFE);
    chk("sub_borrow", carry, 0);
    chk("sub_hi_kept", hi, 32'hA);
    chk("sub_dz_clr", div_zero, 0);
    run(4'b0010, 32'd7, 32'd5, -1);
    chk("sub_nb", {31'd0, carry, lo}, {31'd0, 1'b1, 32'd2});

    run(4'b0110, 32'hF0F0_1234, 32'h0FF0_FF00, -1);
    chk("and", lo, 32'h00F0_1200);
    run(4'b0111, 32'hF0F0_1234, 32'h0FF0_FF00, -1);
    chk("or", lo, 32'hFFF0_FF34);
    run(4'b1000, 32'h0, 32'd5, -1);
    chk("neg", lo, 32'hFFFF_FFFB);
    run(4'b1010, 32'h0, 32'h0000_FFFF, -1);
    chk("not", lo, 32'hFFFF_0000);

    run(4'b1111, 32'h1, 32'd1, -1);
    chk("ror1", lo, 32'h8000_0000);
    run(4'b1110, 32'h8000_0001, 32'd33, -1);
    chk("rol33", lo, 32'h0000_0003);
    run(4'b1111, 32'h1234_5678, 32'd36, -1);
    chk("ror36", lo, 32'h8123_4567);
    run(4'b1100, 32'h1, 32'd33, -1);
    chk("shl33", lo, 0);
    run(4'b1101, 32'h8000_0000, 32'd31, -1);
    chk("shr31", lo, 1);
    run(4'b1101, 32'h8000_0000, 32'd32, -1);
    chk("shr32", lo, 0);
    run(4'b1100, 32'h1, 32'd31, -1);
    chk("shl31", lo, 32'h8000_0000);

    run(4'b0101, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("div_min_m1", {hi, lo}, 64'h0000_0000_8000_0000);
    chk("div_min_dz", div_zero, 0);

    run(4'b0100, 32'h1234, 32'h5678, -1);
    chk("undef_lat", lat, 1);
    chk("undef_keep", {hi, lo}, 64'h0000_0000_8000_0000);

    // start pulsed mid-multiply must be ignored
    run(4'b0011, 32'd3, 32'd4, 5);
    chk("ign_lat", lat, 33);
    chk("ign_prod", {hi, lo}, 64'd12);

    // abort with clr mid-multiply
    @(negedge clk);
    start = 1'b1; op = 4'b0011; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 clr = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_outs", {hi, lo}, 0);
    chk("abort_flags", {61'd0, done, carry, div_zero}, 0);
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    clr = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("abort_stays_idle", {busy, 31'd0, done_cnt[31:0]}, 0);

    run(4'b0001, 32'd2, 32'd3, -1);
    chk("post_abort_add", lo, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
